// File: rtl/dcm_prog_ctrl.sv
// Push-button front-end for the programmable clock divider: synchronises and debounces
// up/down/load buttons, keeps a pending selection and issues commit strobes to the DCM.
module dcm_prog_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  output logic [2:0] prog_sel,
  output logic [2:0] prog_value,
  output logic       update,
  output logic       pending
);

  localparam int unsigned NB = 3;
  localparam int unsigned UP = 0;
  localparam int unsigned DN = 1;
  localparam int unsigned LD = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {INIT, IDLE, COMMIT} state_t;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync0;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    deb;
  logic [NB-1:0]    deb_q;
  logic [NB-1:0]    press;
  logic [NB-1:0]    armed;
  logic [1:0]       sync_ok;
  logic [CNT_W-1:0] cnt [NB];
  state_t           state;
  logic [2:0]       sel_next;

  assign raw = {btn_load, btn_down, btn_up};

  // A button only arms once it has been seen released after reset, so a button held
  // through reset re-qualifies high without producing a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync0   <= '0;
      sync1   <= '0;
      deb     <= '0;
      deb_q   <= '0;
      press   <= '0;
      armed   <= '0;
      sync_ok <= '0;
      for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync0   <= raw;
      sync1   <= sync0;
      sync_ok <= {sync_ok[0], 1'b1};
      deb_q   <= deb;
      press   <= deb & ~deb_q & armed;
      armed   <= armed | ({NB{sync_ok[1]}} & ~sync1);
      for (int unsigned i = 0; i < NB; i++) begin
        if (cnt[i] == CNT_MAX) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else if (sync1[i] != deb[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    sel_next = prog_sel;
    case ({press[DN], press[UP]})
      2'b01:   sel_next = prog_sel + 3'd1;
      2'b10:   sel_next = prog_sel - 3'd1;
      default: sel_next = prog_sel;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      prog_sel   <= '0;
      prog_value <= '0;
      update     <= 1'b0;
      pending    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          prog_value <= prog_sel;
          update     <= 1'b1;
          pending    <= 1'b0;
          state      <= COMMIT;
        end
        IDLE: begin
          if (press[LD]) begin
            // Load wins: commit the pre-change selection and drop same-cycle up/down.
            prog_value <= prog_sel;
            update     <= 1'b1;
            pending    <= 1'b0;
            state      <= COMMIT;
          end else begin
            prog_sel <= sel_next;
            pending  <= (sel_next != prog_value);
          end
        end
        COMMIT: begin
          update   <= 1'b0;
          prog_sel <= sel_next;
          pending  <= (sel_next != prog_value);
          state    <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
